// File: rtl/fifo_vc_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_vc_multi_pkg
// Brief    : Shared helpers, default depth and error-cause codes for the
//            multi-channel virtual-channel FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_vc_multi_pkg;

    localparam int DEFAULT_ADDR_W = 4;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_OVERFLOW  = 2'd1,
        ERR_UNDERFLOW = 2'd2,
        ERR_BOTH      = 2'd3
    } err_cause_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_vc_lane.sv
`default_nettype none
// ============================================================================
// Module   : fifo_vc_lane
// Brief    : One virtual channel: storage, pointers, count, status flags,
//            hysteretic pause and sticky error.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_vc_lane #(
    parameter int DATA_SIZE = 6,
    parameter int ADDR_W    = 4,
    parameter int CNT_W     = ADDR_W + 1
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic [CNT_W-1:0]     afull_th,
    input  logic [CNT_W-1:0]     aempty_th,
    input  logic                 err_clr,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 data_valid,
    output logic [CNT_W-1:0]     count,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 pause,
    output logic                 error
);

    localparam int               c_depth_int = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] c_depth     = CNT_W'(c_depth_int);

    logic [DATA_SIZE-1:0] r_mem [c_depth_int];
    logic [ADDR_W-1:0]    r_wr_ptr;
    logic [ADDR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [DATA_SIZE-1:0] r_data_out;
    logic                 r_data_valid;
    logic                 r_pause;
    logic                 r_error;

    logic                 w_rd_ok;
    logic                 w_wr_ok;
    logic                 w_err_evt;
    logic [CNT_W-1:0]     w_count_nxt;

    assign empty        = (r_count == '0);
    assign full         = (r_count == c_depth);
    assign almost_full  = (r_count >= afull_th);
    assign almost_empty = (r_count != '0) && (r_count <= aempty_th);

    // A full lane still accepts a push when a pop frees the slot this cycle.
    assign w_rd_ok     = rd_en && !empty;
    assign w_wr_ok     = wr_en && (!full || w_rd_ok);
    assign w_err_evt   = (wr_en && !w_wr_ok) || (rd_en && empty);
    assign w_count_nxt = r_count + CNT_W'(w_wr_ok) - CNT_W'(w_rd_ok);

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_pause      <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_count      <= w_count_nxt;
            r_data_valid <= w_rd_ok;
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_ok) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_data_out <= r_mem[r_rd_ptr];
            end
            // Set has priority over clear when thresholds overlap.
            if (w_count_nxt >= afull_th)       r_pause <= 1'b1;
            else if (w_count_nxt <= aempty_th) r_pause <= 1'b0;
            if (w_err_evt)    r_error <= 1'b1;
            else if (err_clr) r_error <= 1'b0;
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign count      = r_count;
    assign pause      = r_pause;
    assign error      = r_error;

endmodule
`default_nettype wire

// File: rtl/fifo_vc_multi.sv
`default_nettype none
// ============================================================================
// Module   : fifo_vc_multi
// Brief    : NUM_VC independent FIFO lanes behind one shared push port with
//            per-channel pop strobes and flattened per-lane status.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_vc_multi
    import fifo_vc_multi_pkg::*;
#(
    parameter int DATA_SIZE = 6,
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int NUM_VC    = 2,
    parameter int VC_W      = (clog2(NUM_VC) < 1) ? 1 : clog2(NUM_VC),
    localparam int CNT_W    = ADDR_W + 1
) (
    input  logic                        clk,
    input  logic                        reset_L,
    input  logic                        push,
    input  logic [VC_W-1:0]             push_vc,
    input  logic [DATA_SIZE-1:0]        data_in,
    input  logic [NUM_VC-1:0]           pop,
    input  logic [CNT_W-1:0]            afull_th,
    input  logic [CNT_W-1:0]            aempty_th,
    input  logic [NUM_VC-1:0]           err_clr,
    output logic [NUM_VC*DATA_SIZE-1:0] data_out,
    output logic [NUM_VC-1:0]           data_valid,
    output logic [NUM_VC*CNT_W-1:0]     data_count,
    output logic [NUM_VC-1:0]           fifo_empty,
    output logic [NUM_VC-1:0]           fifo_full,
    output logic [NUM_VC-1:0]           almost_full,
    output logic [NUM_VC-1:0]           almost_empty,
    output logic [NUM_VC-1:0]           fifo_pause,
    output logic [NUM_VC-1:0]           fifo_error
);

    logic [NUM_VC-1:0] w_wr_en;

    // Out-of-range push_vc matches no lane, so the word is silently dropped.
    for (genvar i = 0; i < NUM_VC; i++) begin : g_lane
        assign w_wr_en[i] = push && (int'(push_vc) == i);

        fifo_vc_lane #(
            .DATA_SIZE (DATA_SIZE),
            .ADDR_W    (ADDR_W),
            .CNT_W     (CNT_W)
        ) u_lane (
            .clk          (clk),
            .reset_L      (reset_L),
            .wr_en        (w_wr_en[i]),
            .rd_en        (pop[i]),
            .data_in      (data_in),
            .afull_th     (afull_th),
            .aempty_th    (aempty_th),
            .err_clr      (err_clr[i]),
            .data_out     (data_out[i*DATA_SIZE +: DATA_SIZE]),
            .data_valid   (data_valid[i]),
            .count        (data_count[i*CNT_W +: CNT_W]),
            .empty        (fifo_empty[i]),
            .full         (fifo_full[i]),
            .almost_full  (almost_full[i]),
            .almost_empty (almost_empty[i]),
            .pause        (fifo_pause[i]),
            .error        (fifo_error[i])
        );
    end

endmodule
`default_nettype wire
